// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_bundle_t;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Valid/ready stream of fetched {pc, inst, fault} from fetch to decode.
interface inst_fetch_ctrl_if;
    import fetch_pkg::*;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_fault;

    modport master (output if_valid, if_pc, if_inst, if_fault, input if_ready);
    modport slave  (input if_valid, if_pc, if_inst, if_fault, output if_ready);

endinterface

// File: rtl/fetch_pc_gen.sv
// PC register with +4 advance, word-aligned redirect and ROM range check.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance_i,
    input  logic        redirect_i,
    input  logic [29:0] redirect_word_i,
    output logic [31:0] pc_o,
    output logic        in_range_o
);

    logic [31:0] pc_q, pc_d;

    // Redirect always wins over the sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = {redirect_word_i, 2'b00};
        end else if (advance_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign in_range_o = ({2'b00, pc_q[31:2]} < MEM_WORDS);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: drives the ROM, registers its output, presents it to decode.
// state | meaning
// BOOT  | one idle cycle after reset, ROM not read
// FETCH | normal fetching, one word per cycle when decode keeps up
// HALT  | no fetching; pending entry still presented until accepted
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = fetch_pkg::NOP_INST
) (
    input  logic               clk,
    input  logic               rst,
    output logic               read_enable_cpu,
    output logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_inst,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               halt_req,
    input  logic               resume,
    inst_fetch_ctrl_if.master  dec,
    output logic               halted,
    output logic               misalign_err
);

    localparam logic [1:0] S_BOOT  = BOOT;
    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_HALT  = HALT;

    logic [1:0]    state_q, state_d;
    fetch_bundle_t bundle_q, bundle_d;
    logic          valid_q, valid_d;
    logic          misalign_q, misalign_d;
    logic [31:0]   pc;
    logic          in_range;
    logic          redir_en, redir_mis, load;

    assign redir_en  = redirect_valid && (state_q != S_BOOT);
    assign redir_mis = redir_en && (redirect_pc[1:0] != 2'b00);
    assign load      = (state_q == S_FETCH) && (!valid_q || dec.if_ready)
                       && !redirect_valid && !halt_req;

    fetch_pc_gen #(
        .MEM_WORDS (MEM_WORDS),
        .RESET_PC  (RESET_PC)
    ) u_pc_gen (
        .clk             (clk),
        .rst             (rst),
        .advance_i       (load),
        .redirect_i      (redir_en),
        .redirect_word_i (redirect_pc[31:2]),
        .pc_o            (pc),
        .in_range_o      (in_range)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: if (halt_req || redir_mis) state_d = S_HALT;
            S_HALT:  if (resume && !halt_req && !redir_en) state_d = S_FETCH;
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        bundle_d = bundle_q;
        if (load) begin
            bundle_d.pc    = pc;
            bundle_d.inst  = in_range ? cpu_inst : NOP_INST;
            bundle_d.fault = !in_range;
        end
    end

    // A redirect flushes the presented entry even while decode is stalled.
    always_comb begin
        valid_d = valid_q;
        if (redir_en) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (dec.if_ready) begin
            valid_d = 1'b0;
        end
    end

    assign misalign_d = misalign_q | redir_mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            bundle_q   <= '{pc: 32'h0, inst: NOP_INST, fault: 1'b0};
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bundle_q   <= bundle_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign read_enable_cpu = load;
    assign cpu_addr        = pc;
    assign dec.if_valid    = valid_q;
    assign dec.if_pc       = bundle_q.pc;
    assign dec.if_inst     = bundle_q.inst;
    assign dec.if_fault    = bundle_q.fault;
    assign halted          = (state_q == S_HALT);
    assign misalign_err    = misalign_q;

endmodule
